// File: rtl/fetch_stage.sv
// fetch_stage: front pipeline stage that reads instructions and hands {PC, instruction} to decode.
//
// Parameters: RESET_PC (fetch address after reset), ADDR_WIDTH, INSTR_WIDTH.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/ready       instruction read request and its handshake
//   imem_rvalid/rdata/error   read response; error marks a bus fault
//   next_stall                decode refuses the held instruction
//   done_next                 output register holds a transferable instruction
//   program_count(_valid)     PC of the held instruction
//   instruction_data(_valid)  held instruction; valid is 0 on a bus fault or trap
//   control_flow_affected     decode requests a redirect
//   jump_target(_valid)       redirect address and its resolution flag
// Build option: define FETCH_MISALIGN_TRAP_EN to turn a misaligned redirect into an
// invalid handoff that halts fetch; otherwise the target is forced word aligned.
module fetch_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_error,
    input  logic                   next_stall,
    output logic                   done_next,
    output logic [ADDR_WIDTH-1:0]  program_count,
    output logic                   program_count_valid,
    output logic [INSTR_WIDTH-1:0] instruction_data,
    output logic                   instruction_data_valid,
    input  logic                   control_flow_affected,
    input  logic [ADDR_WIDTH-1:0]  jump_target,
    input  logic                   jump_target_valid
);
    logic [ADDR_WIDTH-1:0]  fetch_pc, req_pc, out_pc, target;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic out_full, out_ok, outstanding, discard, armed, halted, trap;
    logic cf_armed, redirect_hit, freeze, transfer, accept, resp;

    // armed masks control_flow_affected while the branch that already redirected
    // us still sits in decode
    assign cf_armed     = armed && control_flow_affected;
    assign redirect_hit = cf_armed && jump_target_valid;
    assign freeze       = cf_armed && !jump_target_valid;
    assign done_next    = out_full && !cf_armed;
    assign transfer     = done_next && !next_stall;
    assign imem_req     = !rst && !outstanding && (!out_full || transfer) && !freeze && !halted;
    assign imem_addr    = fetch_pc;
    assign accept       = imem_req && imem_ready;
    assign resp         = imem_rvalid && outstanding;

    assign program_count          = out_pc;
    assign program_count_valid    = out_full;
    assign instruction_data       = out_instr;
    assign instruction_data_valid = out_full && out_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap   = jump_target[1:0] != 2'b00;
    assign target = jump_target;
    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (redirect_hit)
            halted <= trap;
    end
`else
    assign trap   = 1'b0;
    assign halted = 1'b0;
    assign target = jump_target & ~ADDR_WIDTH'(3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_ok      <= 1'b0;
            out_full    <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            armed       <= 1'b1;
        end else begin
            if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            if (redirect_hit)
                fetch_pc <= target;
            outstanding <= accept || (outstanding && !imem_rvalid);
            // a request still in flight after a redirect belongs to the wrong path;
            // a response landing in the redirect cycle itself is dropped below
            discard <= redirect_hit ? (accept || (outstanding && !imem_rvalid)) : (discard && !resp);
            if (redirect_hit) begin
                out_full <= trap;
                if (trap) begin
                    out_pc    <= jump_target;
                    out_instr <= '0;
                    out_ok    <= 1'b0;
                end
            end else if (resp && !discard) begin
                out_full  <= 1'b1;
                out_pc    <= req_pc;
                out_instr <= imem_rdata;
                out_ok    <= !imem_error;
            end else if (transfer) begin
                out_full <= 1'b0;
            end
            if (redirect_hit)
                armed <= 1'b0;
            else if (transfer)
                armed <= 1'b1;
        end
    end
endmodule
